// File: rtl/zigzag_serializer_if.sv
// Handshake bundle for the zigzag serializer: row input side, serial coefficient output side, overflow flag.
interface zigzag_serializer_if #(
    parameter int DW = 12
);
    logic [8*DW-1:0]        row_data;
    logic                   row_vld;
    logic                   in_ready;
    logic                   scan_mode;
    logic signed [DW-1:0]   out_data;
    logic                   out_vld;
    logic                   out_ready;
    logic                   out_sof;
    logic                   out_eob;
    logic                   ovf;

    modport master (
        output row_data, row_vld, scan_mode, out_ready,
        input  in_ready, out_data, out_vld, out_sof, out_eob, ovf
    );

    modport slave (
        input  row_data, row_vld, scan_mode, out_ready,
        output in_ready, out_data, out_vld, out_sof, out_eob, ovf
    );
endinterface

// File: rtl/zigzag_serializer.sv
// Ping-pong 8x8 block buffer: rows in, coefficients out one per handshake in zigzag or raster order.
module zigzag_serializer #(
    parameter int DW         = 12,
    parameter bit ZZ_DEFAULT = 1'b1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    zigzag_serializer_if.slave   bus
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } rd_state_e;

    localparam logic [5:0] ZZ_TBL [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] scan_addr(input logic zz, input logic [5:0] pos);
        logic [5:0] addr;
        if (zz) begin
            addr = ZZ_TBL[pos];
        end else begin
            addr = pos;
        end
        return addr;
    endfunction

    logic [DW-1:0]  mem_q [2][64];

    logic [1:0]     full_q, full_d;
    logic           wr_sel_q, wr_sel_d;
    logic [2:0]     wr_row_q, wr_row_d;
    logic [1:0]     mode_q, mode_d;
    logic           ovf_q, ovf_d;
    logic           in_ready_q;

    rd_state_e      state_q;
    logic           rd_sel_q;
    logic [5:0]     rd_ptr_q;
    logic [DW-1:0]  out_data_q;
    logic           out_vld_q;
    logic           out_sof_q;
    logic           out_eob_q;

    logic           row_acc_s;
    logic           blk_done_s;
    logic           hs_s;
    logic           last_s;
    logic           full_clr_s;
    logic [1:0]     set_mask_s;
    logic [1:0]     clr_mask_s;
    logic           ld_bank_s;
    logic [5:0]     ld_pos_s;
    logic [5:0]     ld_addr_s;
    logic [DW-1:0]  ld_coef_s;

    // in_ready_q always mirrors ~full_q[wr_sel_q], so it can qualify the accept directly.
    assign row_acc_s  = bus.row_vld & in_ready_q;
    assign blk_done_s = row_acc_s & (wr_row_q == 3'd7);
    assign hs_s       = out_vld_q & bus.out_ready;
    assign last_s     = (rd_ptr_q == 6'd63);
    assign full_clr_s = (state_q == S_STREAM) & hs_s & last_s;
    assign set_mask_s = blk_done_s ? (2'b01 << wr_sel_q) : 2'b00;
    assign clr_mask_s = full_clr_s ? (2'b01 << rd_sel_q) : 2'b00;

    // Write-side next state: set and clear always target different banks.
    always_comb begin
        full_d   = (full_q | set_mask_s) & ~clr_mask_s;
        wr_row_d = row_acc_s ? (wr_row_q + 3'd1) : wr_row_q;
        wr_sel_d = blk_done_s ? ~wr_sel_q : wr_sel_q;
        ovf_d    = ovf_q | (bus.row_vld & ~in_ready_q);
        mode_d   = mode_q;
        if (blk_done_s) begin
            mode_d[wr_sel_q] = bus.scan_mode;
        end else begin
            mode_d = mode_q;
        end
    end

    // Write-side bookkeeping registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            full_q     <= 2'b00;
            wr_sel_q   <= 1'b0;
            wr_row_q   <= 3'd0;
            mode_q     <= {2{ZZ_DEFAULT}};
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            full_q     <= full_d;
            wr_sel_q   <= wr_sel_d;
            wr_row_q   <= wr_row_d;
            mode_q     <= mode_d;
            ovf_q      <= ovf_d;
            in_ready_q <= ~full_d[wr_sel_d];
        end
    end

    // Row storage; contents are don't-care until a full flag covers them.
    always_ff @(posedge sys_clk) begin
        if (row_acc_s) begin
            for (int c = 0; c < 8; c++) begin
                mem_q[wr_sel_q][{wr_row_q, 3'(c)}] <= bus.row_data[(7-c)*DW +: DW];
            end
        end
    end

    // Coefficient to load on the next output update: next in this bank or first of the other.
    always_comb begin
        ld_bank_s = rd_sel_q;
        ld_pos_s  = 6'd0;
        if (state_q == S_STREAM) begin
            if (last_s) begin
                ld_bank_s = ~rd_sel_q;
                ld_pos_s  = 6'd0;
            end else begin
                ld_bank_s = rd_sel_q;
                ld_pos_s  = rd_ptr_q + 6'd1;
            end
        end else begin
            ld_bank_s = rd_sel_q;
            ld_pos_s  = 6'd0;
        end
    end

    assign ld_addr_s = scan_addr(mode_q[ld_bank_s], ld_pos_s);
    assign ld_coef_s = mem_q[ld_bank_s][ld_addr_s];

    // Read FSM with registered output stage; outputs hold while stalled.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            rd_sel_q   <= 1'b0;
            rd_ptr_q   <= 6'd0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            out_sof_q  <= 1'b0;
            out_eob_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (full_q[rd_sel_q]) begin
                        state_q    <= S_STREAM;
                        rd_ptr_q   <= 6'd0;
                        out_data_q <= ld_coef_s;
                        out_vld_q  <= 1'b1;
                        out_sof_q  <= 1'b1;
                        out_eob_q  <= 1'b0;
                    end else begin
                        state_q    <= S_IDLE;
                    end
                end
                S_STREAM: begin
                    if (hs_s && !last_s) begin
                        rd_ptr_q   <= rd_ptr_q + 6'd1;
                        out_data_q <= ld_coef_s;
                        out_sof_q  <= 1'b0;
                        out_eob_q  <= (rd_ptr_q == 6'd62);
                    end else if (hs_s) begin
                        rd_sel_q   <= ~rd_sel_q;
                        rd_ptr_q   <= 6'd0;
                        // Other bank already full: continue without an idle cycle.
                        if (full_q[~rd_sel_q]) begin
                            out_data_q <= ld_coef_s;
                            out_sof_q  <= 1'b1;
                            out_eob_q  <= 1'b0;
                        end else begin
                            state_q    <= S_IDLE;
                            out_vld_q  <= 1'b0;
                            out_sof_q  <= 1'b0;
                            out_eob_q  <= 1'b0;
                        end
                    end else begin
                        state_q    <= S_STREAM;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    out_vld_q <= 1'b0;
                    out_sof_q <= 1'b0;
                    out_eob_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.out_data = out_data_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.out_sof  = out_sof_q;
    assign bus.out_eob  = out_eob_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_zigzag_serializer.sv
// Scoreboard bench for zigzag_serializer: driver pushes expected coefficient streams, a monitor pops and compares.
module tb_zigzag_serializer;
    localparam int DW = 12;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    zigzag_serializer_if #(.DW(DW)) bus ();

    zigzag_serializer #(.DW(DW), .ZZ_DEFAULT(1'b1)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          sof;
        logic          eob;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            pops = 0;
    int            cyc = 0;
    int            rdy_mode = 1;
    int            zz_ord[64];
    logic [DW-1:0] blk_v[64];
    int            acc_cyc = 0;
    int            acc_pops = 0;
    logic          hold_v = 1'b0;
    logic [DW+1:0] hold_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Zigzag order derived by walking anti-diagonals, alternating direction.
    function automatic void build_zz();
        int k;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zz_ord[k] = r*8 + (s-r); k++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zz_ord[k] = r*8 + (s-r); k++; end
            end
        end
    endfunction

    function automatic void push_block(input logic mode);
        for (int k = 0; k < 64; k++) begin
            int idx;
            idx = mode ? zz_ord[k] : k;
            exp_q.push_back('{d: blk_v[idx], sof: (k == 0), eob: (k == 63)});
        end
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_row(input int r, input logic mode, output bit acc);
        logic [8*DW-1:0] w;
        for (int c = 0; c < 8; c++) w[(7-c)*DW +: DW] = blk_v[r*8+c];
        bus.row_data  = w;
        bus.scan_mode = mode;
        bus.row_vld   = 1'b1;
        acc = bus.in_ready;
        step();
        bus.row_vld = 1'b0;
    endtask

    task automatic send_block(input int mode_sel, input bit gaps);
        for (int r = 0; r < 8; r++) begin
            int   n;
            bit   acc;
            logic m;
            n = 0;
            if (gaps && ($urandom % 3 == 0)) step();
            while (!bus.in_ready && n < 3000) begin step(); n++; end
            if (n >= 3000) begin
                total++; bad++;
                $display("FAIL in_ready_timeout: got 0 want 1");
                return;
            end
            m = (mode_sel == 2) ? 1'($urandom_range(0, 1)) : mode_sel[0];
            send_row(r, m, acc);
            if (r == 7) begin
                push_block(m);
                acc_cyc  = cyc;
                acc_pops = pops;
            end
        end
    endtask

    task automatic expect_run(input int n, input int extra);
        int g;
        g = 0;
        while (pops < acc_pops + n && g < 5000) begin step(); g++; end
        chk("run_len", cyc - acc_cyc, n + extra + 1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 6000) begin step(); g++; end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
        repeat (3) step();
        chk("idle_after_drain", bus.out_vld, 1'b0);
    endtask

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    // out_ready policy: 0 low, 1 high, 2 random, otherwise left to the test.
    initial forever begin
        @(posedge sys_clk);
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            2:       bus.out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // Monitor: stall stability and scoreboard pop on every output handshake.
    initial forever begin
        @(negedge sys_clk);
        if (sys_rst_n !== 1'b1) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("hold_stable", {bus.out_vld, bus.out_sof, bus.out_eob, bus.out_data}, {1'b1, hold_val});
            hold_v   = bus.out_vld && !bus.out_ready;
            hold_val = {bus.out_sof, bus.out_eob, bus.out_data};
            if (bus.out_vld && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got %0h want none", $unsigned(bus.out_data));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", $unsigned(bus.out_data), e.d);
                    chk("out_sof", bus.out_sof, e.sof);
                    chk("out_eob", bus.out_eob, e.eob);
                end
                pops++;
            end
        end
    end

    initial begin
        bit acc;
        int a_cyc;
        int a_pops;
        int p;
        build_zz();
        bus.row_vld   = 1'b0;
        bus.row_data  = '0;
        bus.scan_mode = 1'b1;
        bus.out_ready = 1'b1;
        sys_rst_n     = 1'b0;

        repeat (2) step();
        chk("rst_out_vld", bus.out_vld, 1'b0);
        chk("rst_out_sof", bus.out_sof, 1'b0);
        chk("rst_out_eob", bus.out_eob, 1'b0);
        chk("rst_out_data", $unsigned(bus.out_data), 0);
        chk("rst_ovf", bus.ovf, 1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // Zigzag block of index values, latency and contiguity.
        for (int i = 0; i < 64; i++) blk_v[i] = DW'(i);
        send_block(1, 1'b0);
        chk("lat_before", bus.out_vld, 1'b0);
        step();
        chk("lat_first", bus.out_vld, 1'b1);
        expect_run(64, 0);
        drain();

        // Raster block.
        send_block(0, 1'b0);
        chk("raster_lat_before", bus.out_vld, 1'b0);
        step();
        chk("raster_lat_first", bus.out_vld, 1'b1);
        expect_run(64, 0);
        drain();

        // Two blocks back-to-back, 128 outputs with no gap.
        send_block(1, 1'b0);
        a_cyc  = acc_cyc;
        a_pops = acc_pops;
        for (int i = 0; i < 64; i++) blk_v[i] = DW'(100 + i);
        send_block(1, 1'b0);
        acc_cyc  = a_cyc;
        acc_pops = a_pops;
        expect_run(128, 0);
        drain();

        // Five-cycle stall at output 10.
        for (int i = 0; i < 64; i++) blk_v[i] = DW'($urandom);
        send_block(1, 1'b0);
        p = 0;
        while (pops < acc_pops + 10 && p < 500) begin step(); p++; end
        #1;
        rdy_mode = 3;
        bus.out_ready = 1'b0;
        repeat (5) step();
        bus.out_ready = 1'b1;
        rdy_mode = 1;
        expect_run(64, 5);
        drain();

        // Overflow: 17 rows with output stalled.
        rdy_mode = 0;
        for (int i = 0; i < 64; i++) blk_v[i] = DW'($urandom);
        send_block(2, 1'b0);
        for (int i = 0; i < 64; i++) blk_v[i] = DW'($urandom);
        send_block(2, 1'b0);
        chk("in_ready_full", bus.in_ready, 1'b0);
        chk("ovf_before", bus.ovf, 1'b0);
        for (int i = 0; i < 64; i++) blk_v[i] = DW'($urandom);
        send_row(0, 1'b1, acc);
        chk("row17_dropped", acc, 1'b0);
        chk("ovf_set", bus.ovf, 1'b1);
        rdy_mode = 2;
        drain();
        chk("ovf_sticky", bus.ovf, 1'b1);

        // Random blocks, per-row random scan_mode, random gaps and backpressure.
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 64; i++) blk_v[i] = DW'($urandom);
            send_block(2, 1'b1);
        end
        drain();

        // Reset mid-block discards partial rows.
        rdy_mode = 1;
        for (int i = 0; i < 64; i++) blk_v[i] = DW'($urandom);
        for (int r = 0; r < 3; r++) send_row(r, 1'b1, acc);
        sys_rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_vld", bus.out_vld, 1'b0);
        chk("midrst_ovf", bus.ovf, 1'b0);
        repeat (2) step();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 64; i++) blk_v[i] = DW'(7);
        p = pops;
        send_block(2, 1'b0);
        drain();
        chk("midrst_count", pops - p, 64);
        chk("midrst_ovf_after", bus.ovf, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
